// File: rtl/spi_slave_axis_egress.sv
// SPI slave transmit path: AXI-Stream bytes -> small FIFO -> MISO, one byte per 8 spi_clk edges.
// Optional saturating underrun counter is built only when SPI_SLAVE_EGRESS_UNDERRUN_CNT_EN is defined.
module spi_slave_axis_egress #(
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [7:0] IDLE_BYTE       = 8'h00,
    parameter bit         USE_CHIP_SELECT = 1'b0,
    parameter bit         MSB_FIRST       = 1'b1
) (
    input  logic       spi_clk,
    input  logic       resn,
    input  logic       spi_csn,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       err_underrun,
    output logic [7:0] underrun_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        cs_abort;
    logic        load;
    logic        underrun;
    logic [7:0]  load_byte;
    logic [2:0]  cnt;
    logic [6:0]  shift_reg;

    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);

    assign s_axis_tready = !fifo_full;
    assign push          = s_axis_tvalid && !fifo_full;
    assign cs_abort      = USE_CHIP_SELECT && spi_csn;
    assign load          = !cs_abort && (cnt == 3'd0);
    assign pop           = load && !fifo_empty;
    assign underrun      = load && fifo_empty;
    assign load_byte     = fifo_empty ? IDLE_BYTE : mem[rd_ptr[AW-1:0]];

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge spi_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge spi_clk or negedge resn) begin
        if (!resn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // A chip-select abort drops the partial byte; the next selected edge starts a fresh LOAD.
    always_ff @(posedge spi_clk or negedge resn) begin
        if (!resn) begin
            cnt       <= 3'd0;
            shift_reg <= 7'd0;
            spi_miso  <= 1'b0;
        end else if (cs_abort) begin
            cnt      <= 3'd0;
            spi_miso <= 1'b0;
        end else if (load) begin
            cnt <= 3'd1;
            if (MSB_FIRST) begin
                spi_miso  <= load_byte[7];
                shift_reg <= load_byte[6:0];
            end else begin
                spi_miso  <= load_byte[0];
                shift_reg <= load_byte[7:1];
            end
        end else begin
            cnt <= cnt + 3'd1;
            if (MSB_FIRST) begin
                spi_miso  <= shift_reg[6];
                shift_reg <= {shift_reg[5:0], 1'b0};
            end else begin
                spi_miso  <= shift_reg[0];
                shift_reg <= {1'b0, shift_reg[6:1]};
            end
        end
    end

    always_ff @(posedge spi_clk or negedge resn) begin
        if (!resn) begin
            spi_miso_oe  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            spi_miso_oe <= USE_CHIP_SELECT ? !spi_csn : 1'b1;
            if (underrun) begin
                err_underrun <= 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_EGRESS_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt_q;

    always_ff @(posedge spi_clk or negedge resn) begin
        if (!resn) begin
            underrun_cnt_q <= 8'h00;
        end else if (underrun && (underrun_cnt_q != 8'hFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 8'd1;
        end
    end

    assign underrun_count = underrun_cnt_q;
`else
    assign underrun_count = 8'h00;
`endif

endmodule
